// File: rtl/gpio_ahb_pkg.sv
// Shared constants for the AHBGPIO front-end arbiter:
// AHB transfer encodings, FSM states and GPIO register offsets.
package gpio_ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    localparam logic [31:0] GPIO_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] GPIO_DIR_OFS  = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin : pick
        int                 j;
        logic [IDX_W-1:0]   sel;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            sel = IDX_W'(j);
            if (!any && valid[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/gpio_ahb_arbiter.sv
// Round-robin front end sharing one AHB-Lite GPIO slave between
// NUM_REQ requesters; one non-pipelined transfer at a time.
module gpio_ahb_arbiter
    import gpio_ahb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      HSEL,
    output logic [ADDR_W-1:0]         HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [DATA_W-1:0]         HWDATA,
    output logic                      HREADY,
    input  logic                      HREADYOUT,
    input  logic [DATA_W-1:0]         HRDATA,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic               lat_write;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               done_ok;
    logic               done_to;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Abort on the wait cycle that would bring the count to TIMEOUT.
    assign done_ok = (state == ST_DATA) && HREADYOUT;
    assign done_to = (state == ST_DATA) && !HREADYOUT &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        HSEL      = 1'b0;
        HADDR     = '0;
        HTRANS    = HTRANS_IDLE;
        HWRITE    = 1'b0;
        HWDATA    = '0;
        HREADY    = 1'b1;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (grant_any) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                busy      = 1'b1;
                HSEL      = 1'b1;
                HTRANS    = HTRANS_NONSEQ;
                HADDR     = lat_addr;
                HWRITE    = lat_write;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                busy   = 1'b1;
                HREADY = HREADYOUT;
                HWDATA = lat_write ? lat_wdata : '0;
                if (done_ok || done_to) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            owner     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (state == ST_IDLE && grant_any) begin
                owner     <= grant_idx;
                lat_write <= req_write[grant_idx];
                lat_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                lat_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
            end
            if (state == ST_ADDR) begin
                wait_cnt <= '0;
            end else if (state == ST_DATA && !HREADYOUT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done_ok || done_to) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_err   <= done_to;
                rsp_rdata <= (done_ok && !lat_write) ? HRDATA : '0;
                ptr       <= (owner == IDX_W'(NUM_REQ - 1)) ?
                             '0 : owner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_ahb_arbiter.sv
// Self-checking bench for gpio_ahb_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_gpio_ahb_arbiter;
    import gpio_ahb_pkg::*;

    localparam int NR = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_write;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            HSEL;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [31:0]     HWDATA;
    logic            HREADY;
    logic            HREADYOUT;
    logic [31:0]     HRDATA;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural AHB slave state
    bit          s_active;
    int          s_wait;
    logic [31:0] s_addr;
    bit          s_write;
    logic [31:0] s_mem [16];
    int          nxt_wait;

    gpio_ahb_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic set_req(input logic [1:0] r, input logic v,
                           input logic w, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid[r]             = v;
        req_write[r]             = w;
        req_addr[{r, 5'b0} +: 32]  = a;
        req_wdata[{r, 5'b0} +: 32] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // One clock: the slave samples the bus at the edge and updates after it.
    task automatic tick();
        bit          ap;
        bit          hr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          w;
        ap = HSEL && (HTRANS == HTRANS_NONSEQ) && HREADY;
        hr = HREADYOUT;
        a  = HADDR;
        w  = HWRITE;
        wd = HWDATA;
        @(posedge clk);
        #1;
        if (s_active && hr) begin
            if (s_write) s_mem[s_addr[5:2]] = wd;
            s_active = 0;
        end else if (s_active) begin
            s_wait = s_wait - 1;
        end
        if (ap) begin
            s_active = 1;
            s_addr   = a;
            s_write  = w;
            s_wait   = nxt_wait;
        end
        HREADYOUT = !s_active || (s_wait == 0);
        HRDATA = (s_active && s_wait == 0 && !s_write) ?
                 s_mem[s_addr[5:2]] : $urandom;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        s_active  = 0;
        nxt_wait  = 0;
        HREADYOUT = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        s_active  = 0;
        nxt_wait  = 0;
        HREADYOUT = 1'b1;
        HRDATA    = '0;
        #1;
        vectors++; if (HSEL !== 1'b0) begin miscompares++; $display("FAIL rst_hsel: got %h want 0", HSEL); end
        vectors++; if (HTRANS !== HTRANS_IDLE) begin miscompares++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
        vectors++; if (HREADY !== 1'b1) begin miscompares++; $display("FAIL rst_hready: got %h want 1", HREADY); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %h want 0", busy); end
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rst_ready: got %h want 0", req_ready); end
        vectors++; if (rsp_valid !== 3'b000) begin miscompares++; $display("FAIL rst_rspv: got %h want 0", rsp_valid); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %h want 0", rsp_err); end
        vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
        vectors++; if (HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0) begin miscompares++; $display("FAIL rst_bus: got %h/%h/%h want 0/0/0", HADDR, HWDATA, HWRITE); end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        nxt_wait = 0;
        set_req(2'd0, 1'b1, 1'b1, GPIO_DATA_OFS, 32'h0000_00A5);
        half();
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL wr_ready: got %b want 001", req_ready); end
        tick();
        set_req(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        half();
        vectors++; if (HSEL !== 1'b1 || HTRANS !== HTRANS_NONSEQ) begin miscompares++; $display("FAIL wr_addr_phase: got sel=%h trans=%h want 1/2", HSEL, HTRANS); end
        vectors++; if (HADDR !== GPIO_DATA_OFS || HWRITE !== 1'b1) begin miscompares++; $display("FAIL wr_addr: got %h/%h want 0/1", HADDR, HWRITE); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %h want 1", busy); end
        tick();
        half();
        vectors++; if (HTRANS !== HTRANS_IDLE || HSEL !== 1'b0) begin miscompares++; $display("FAIL wr_data_phase: got sel=%h trans=%h want 0/0", HSEL, HTRANS); end
        vectors++; if (HWDATA !== 32'h0000_00A5) begin miscompares++; $display("FAIL wr_hwdata: got %h want a5", HWDATA); end
        tick();
        half();
        vectors++; if (rsp_valid !== 3'b001) begin miscompares++; $display("FAIL wr_rspv: got %b want 001", rsp_valid); end
        vectors++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL wr_rsp: got err=%h rdata=%h want 0/0", rsp_err, rsp_rdata); end
        vectors++; if (s_mem[0] !== 32'h0000_00A5) begin miscompares++; $display("FAIL wr_gpioout: got %h want a5", s_mem[0]); end
        tick();
    endtask

    task automatic test_read_wait();
        s_mem[1] = 32'h0000_1234;
        nxt_wait = 2;
        set_req(2'd1, 1'b1, 1'b0, GPIO_DIR_OFS, 32'hFFFF_FFFF);
        half();
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL rd_ready: got %b want 010", req_ready); end
        tick();
        set_req(2'd1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            half();
            if (k == 1) begin
                vectors++; if (HTRANS !== HTRANS_NONSEQ || HWRITE !== 1'b0 || HADDR !== GPIO_DIR_OFS) begin miscompares++; $display("FAIL rd_addr: got %h/%h/%h want 2/0/4", HTRANS, HWRITE, HADDR); end
            end
            if (k >= 2 && k <= 4) begin
                vectors++; if (HWDATA !== 32'h0) begin miscompares++; $display("FAIL rd_hwdata k=%0d: got %h want 0", k, HWDATA); end
                vectors++; if (HREADY !== 1'(k == 4)) begin miscompares++; $display("FAIL rd_hready k=%0d: got %h want %h", k, HREADY, k == 4); end
            end
            if (k < 5) begin
                vectors++; if (rsp_valid !== 3'b000) begin miscompares++; $display("FAIL rd_early k=%0d: got %b want 000", k, rsp_valid); end
            end else begin
                vectors++; if (rsp_valid !== 3'b010) begin miscompares++; $display("FAIL rd_rspv: got %b want 010", rsp_valid); end
                vectors++; if (rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rd_rsp: got %h/%h want 1234/0", rsp_rdata, rsp_err); end
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        int n;
        do_reset();
        nxt_wait = 0;
        set_req(2'd0, 1'b1, 1'b0, GPIO_DATA_OFS, 32'h0);
        set_req(2'd1, 1'b1, 1'b0, GPIO_DIR_OFS, 32'h0);
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            half();
            if (req_ready !== 3'b000) begin
                vectors++; if (req_ready !== ((n % 2 == 0) ? 3'b001 : 3'b010)) begin miscompares++; $display("FAIL fair_order n=%0d: got %b want %b", n, req_ready, (n % 2 == 0) ? 3'b001 : 3'b010); end
                n++;
            end
            tick();
        end
        vectors++; if (n != 6) begin miscompares++; $display("FAIL fair_count: got %0d want 6", n); end
        clear_reqs();
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        do_reset();
        nxt_wait = 1000;
        set_req(2'd0, 1'b1, 1'b0, GPIO_DATA_OFS, 32'h0);
        half();
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL to_ready: got %b want 001", req_ready); end
        tick();
        set_req(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 18; k++) begin
            if (k == 18) begin
                set_req(2'd0, 1'b1, 1'b0, GPIO_DATA_OFS, 32'h0);
                set_req(2'd1, 1'b1, 1'b0, GPIO_DIR_OFS, 32'h0);
                nxt_wait = 0;
            end
            half();
            if (k < 18) begin
                vectors++; if (rsp_valid !== 3'b000) begin miscompares++; $display("FAIL to_early k=%0d: got %b want 000", k, rsp_valid); end
            end else begin
                vectors++; if (rsp_valid !== 3'b001) begin miscompares++; $display("FAIL to_rspv: got %b want 001", rsp_valid); end
                vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL to_rsp: got err=%h rdata=%h want 1/0", rsp_err, rsp_rdata); end
                vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL to_next: got %b want 010", req_ready); end
            end
            tick();
        end
        clear_reqs();
        half();
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL to_err_clr: got %h want 0", rsp_err); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        nxt_wait = 0;
        set_req(2'd0, 1'b1, 1'b1, GPIO_DATA_OFS, 32'h5A);
        half();
        tick();
        clear_reqs();
        tick();
        tick();
        set_req(2'd1, 1'b1, 1'b0, GPIO_DIR_OFS, 32'h0);
        nxt_wait = 5;
        half();
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL rm_ready: got %b want 010", req_ready); end
        tick();
        clear_reqs();
        tick();
        #2;
        reset = 1'b1;
        s_active = 0;
        #1;
        vectors++; if (HSEL !== 1'b0 || HTRANS !== HTRANS_IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL rm_bus: got sel=%h trans=%h busy=%h want 0/0/0", HSEL, HTRANS, busy); end
        for (int k = 0; k < 3; k++) begin
            half();
            vectors++; if (rsp_valid !== 3'b000) begin miscompares++; $display("FAIL rm_rspv k=%0d: got %b want 000", k, rsp_valid); end
            tick();
        end
        reset = 1'b0;
        nxt_wait = 0;
        set_req(2'd0, 1'b1, 1'b0, GPIO_DATA_OFS, 32'h0);
        set_req(2'd1, 1'b1, 1'b0, GPIO_DIR_OFS, 32'h0);
        half();
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL rm_first: got %b want 001", req_ready); end
        tick();
        clear_reqs();
        half();
        vectors++; if (rsp_valid !== 3'b000) begin miscompares++; $display("FAIL rm_stale: got %b want 000", rsp_valid); end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        nxt_wait = 0;
        set_req(2'd0, 1'b1, 1'b0, GPIO_DATA_OFS, 32'h0);
        half();
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL bb_ready0: got %b want 001", req_ready); end
        tick();
        set_req(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(2'd1, 1'b1, 1'b1, GPIO_DIR_OFS, 32'h0F);
        half();
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL bb_wait_a: got %b want 000", req_ready); end
        tick();
        half();
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL bb_wait_d: got %b want 000", req_ready); end
        tick();
        set_req(2'd0, 1'b1, 1'b0, GPIO_DATA_OFS, 32'h0);
        half();
        vectors++; if (rsp_valid !== 3'b001 || req_ready !== 3'b010) begin miscompares++; $display("FAIL bb_swap: got rsp=%b ready=%b want 001/010", rsp_valid, req_ready); end
        tick();
        clear_reqs();
        repeat (4) tick();
    endtask

    task automatic test_random();
        bit          pend [NR];
        bit          pw   [NR];
        logic [31:0] pa   [NR];
        logic [31:0] pd   [NR];
        logic [31:0] ref_mem [16];
        int          m_ptr;
        bit          m_busy;
        int          m_owner;
        int          m_rsp;
        bit          m_err;
        bit          m_w;
        logic [31:0] m_a;
        logic [31:0] m_d;
        logic [31:0] m_rdata;
        logic [NR-1:0] exp_rr;
        logic [NR-1:0] exp_rv;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          g;
        int          w;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_mem[i]   = $urandom;
            ref_mem[i] = s_mem[i];
        end
        for (int r = 0; r < NR; r++) pend[r] = 0;
        m_ptr = 0;
        m_busy = 0;
        m_owner = 0;
        m_rsp = 0;
        m_err = 0;
        m_w = 0;
        m_a = '0;
        m_d = '0;
        m_rdata = '0;
        exp_rdata = '0;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && c < 700 && $urandom_range(3) == 0) begin
                    pend[r] = 1;
                    pw[r]   = 1'($urandom_range(1));
                    pa[r]   = {$urandom_range(32'h03FF_FFFF), 6'($urandom_range(15) << 2)};
                    pd[r]   = $urandom;
                end else if (pend[r] && $urandom_range(15) == 0) begin
                    pend[r] = 0;
                end
                set_req(2'(r), pend[r], pw[r], pa[r], pd[r]);
            end
            exp_rv  = '0;
            exp_err = 0;
            if (m_busy && c == m_rsp) begin
                exp_rv    = NR'(1 << m_owner);
                exp_err   = m_err;
                exp_rdata = m_rdata;
                m_busy    = 0;
                m_ptr     = (m_owner + 1) % NR;
                if (!m_err && m_w) ref_mem[m_a[5:2]] = m_d;
            end
            exp_rr = '0;
            g = -1;
            if (!m_busy) begin
                for (int i = 0; i < NR; i++) begin
                    if (g < 0 && pend[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
                end
            end
            if (g >= 0) begin
                exp_rr  = NR'(1 << g);
                m_busy  = 1;
                m_owner = g;
                w = ($urandom_range(7) == 0) ? 1000 : int'($urandom_range(3));
                nxt_wait = w;
                m_w = pw[g];
                m_a = pa[g];
                m_d = pd[g];
                if (w < TO) begin
                    m_rsp   = c + 3 + w;
                    m_err   = 0;
                    m_rdata = m_w ? 32'h0 : ref_mem[m_a[5:2]];
                end else begin
                    m_rsp   = c + 2 + TO;
                    m_err   = 1;
                    m_rdata = 32'h0;
                end
            end
            half();
            vectors++; if (req_ready !== exp_rr) begin miscompares++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, exp_rr); end
            vectors++; if (rsp_valid !== exp_rv) begin miscompares++; $display("FAIL rnd_rspv c=%0d: got %b want %b", c, rsp_valid, exp_rv); end
            vectors++; if (rsp_err !== exp_err) begin miscompares++; $display("FAIL rnd_err c=%0d: got %h want %h", c, rsp_err, exp_err); end
            if (exp_rv != '0) begin
                vectors++; if (rsp_rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rsp_rdata, exp_rdata); end
            end
            if (g >= 0) pend[g] = 0;
            tick();
        end
        vectors++; if (m_busy) begin miscompares++; $display("FAIL rnd_drain: got busy=1 want 0 (response never seen)"); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end

endmodule

// File: doc/gpio_ahb_arbiter.md
Name: gpio_ahb_arbiter

Overview:
AHB-Lite single-master front end that shares the AHBGPIO slave between NUM_REQ independent requesters (e.g. sequencer, loopback checker, error injector). It grants one requester at a time in round-robin order and runs one non-pipelined AHB transfer (address phase, then data phase). It waits on HREADYOUT, returns read data or a timeout error to the granted requester, then rearbitrates. It sits between the test/stimulus layer and the AHBGPIO HSEL/HADDR/HTRANS/HWRITE/HWDATA/HREADY pins.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, AHB address width
DATA_W, 32, AHB data width
TIMEOUT, 16, max data-phase wait cycles with HREADYOUT low before abort

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed per-requester address
req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data
req_ready  out  NUM_REQ  one-hot accept pulse; command taken when valid & ready
rsp_valid  out  NUM_REQ  one-hot completion pulse to the owning requester
rsp_rdata  out  DATA_W  read data, valid with rsp_valid (write: 0)
rsp_err  out  1  timeout flag, valid with rsp_valid
HSEL  out  1  slave select
HADDR  out  ADDR_W  transfer address
HTRANS  out  2  IDLE 2'b00 / NONSEQ 2'b10
HWRITE  out  1  transfer direction
HWDATA  out  DATA_W  write data, data phase
HREADY  out  1  bus ready fed to slave (= HREADYOUT in DATA, 1 otherwise)
HREADYOUT  in  1  slave ready
HRDATA  in  DATA_W  slave read data
busy  out  1  high in ADDR or DATA

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except HREADY=1; rr pointer = 0 (requester 0 has top priority first); timeout counter 0; latched command cleared.
- FSM IDLE -> ADDR -> DATA -> IDLE. No back-to-back pipelining; minimum 3 cycles per transfer.
- IDLE: if any req_valid, pick the first valid index at or after the rr pointer (wrapping modulo NUM_REQ). Assert req_ready[g] combinationally that cycle. Latch write/addr/wdata and g. Go to ADDR. No valid: stay, HTRANS=IDLE, HSEL=0.
- ADDR (1 cycle): HSEL=1, HTRANS=NONSEQ, HADDR/HWRITE from latch. Go to DATA.
- DATA: HSEL=0, HTRANS=IDLE. HWDATA = latched wdata for writes, 0 for reads. HWDATA is held stable for the whole data phase. The counter increments each cycle HREADYOUT=0.
  - HREADYOUT=1: rsp_valid[g]=1 for 1 cycle (registered, next cycle). rsp_rdata = HRDATA for reads (sampled this edge), 0 for writes. rsp_err=0. rr pointer = g+1 mod NUM_REQ. Go to IDLE.
  - Counter reaches TIMEOUT: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0. rr pointer advances. Go to IDLE. The slave is not re-addressed.
- Accept-to-response latency with zero wait states: req_ready at cycle N, address phase N+1, data phase N+2, rsp_valid at N+3.
- Requests arriving while busy wait with valid held; req_ready stays 0. A requester may drop valid before grant with no effect.
- The granted requester may present a new valid in the same cycle rsp_valid fires. It is considered in the next IDLE cycle with the rotated priority.
- The rsp outputs hold their last values when rsp_valid=0, except rsp_err, which is 0 outside a response.
- Reset mid-transfer: the bus returns to IDLE immediately and no rsp_valid is issued for the aborted command.
- An address outside the GPIO map is passed through unchanged; decode is the slave's job.

Decomposition:
- Package gpio_ahb_pkg: HTRANS_IDLE / HTRANS_NONSEQ constants; state enum (ST_IDLE, ST_ADDR, ST_DATA); GPIO register offsets GPIO_DATA_OFS=0x00, GPIO_DIR_OFS=0x04.
- One sub-module rr_arbiter (NUM_REQ): valid vector + pointer in, one-hot grant + index out, purely combinational.
- The FSM, latch, counter and AHB drive stay in gpio_ahb_arbiter.

Test Plan:
- Single write, zero wait: req 0 writes 0x0000_00A5 to GPIO_DATA_OFS → HTRANS=NONSEQ one cycle later; HWDATA=0xA5 next cycle; rsp_valid[0] 3 cycles after accept; rsp_err=0; GPIOOUT shows 0xA5.
- Read with 2 wait states: slave holds HREADYOUT low 2 cycles, HRDATA=0x1234 → rsp_rdata=0x1234, rsp_valid at accept+5, HWDATA=0 throughout.
- Fairness: req 0 and req 1 hold valid continuously for 6 transfers → grant order 0,1,0,1,0,1; neither is starved.
- Timeout: TIMEOUT=16, HREADYOUT stuck low → rsp_valid[g] with rsp_err=1 exactly 16 cycles into the data phase; next grant goes to the other requester.
- Reset mid-DATA: assert reset during the data phase → HSEL/HTRANS/busy at 0 before the next edge; no rsp_valid; after release req 0 is granted first.
- Simultaneous complete and new request: owner re-asserts valid on its rsp cycle while the other requester is waiting → the other requester is granted next.
